// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch/decode boundary.
//   WIDTH        : native datapath width (PC and instruction word)
//   NOP_INST     : instruction shown to decode when no beat is valid
//                  (MIPS sll $0,$0,0 encodes as all zeros)
//   PC_INC       : sequential PC increment in bytes
//   fetch_beat_t : one fetched beat {pc, inst}
package cpu_pkg;

    localparam int              WIDTH    = 32;
    localparam logic [WIDTH-1:0] NOP_INST = 32'h0000_0000;
    localparam int              PC_INC   = 4;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] inst;
    } fetch_beat_t;

endpackage

// File: rtl/pipe_slot.sv
// Single pipeline slot: a beat register plus its valid flag.
//   clk, rst : clock, asynchronous active-high reset (clears valid and data)
//   load     : capture d and mark the slot valid
//   clr      : mark the slot empty (data left stale); wins over load
//   d        : beat to capture
//   vld, q   : registered valid flag and beat
module pipe_slot
    import cpu_pkg::*;
#(
    parameter type beat_t = fetch_beat_t
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  clr,
    input  beat_t d,
    output logic  vld,
    output beat_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Holds {pc, inst, pc+4} between fetch and decode with a valid/ready
// handshake. in_ready is driven from registered state only, so a decode
// stall reaches fetch one cycle late; the skid slot catches the beat fetch
// sent during that cycle. flush empties both slots and drops the incoming
// beat. Debug counters track stall cycles and flush cycles.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : fetch-side handshake
//   in_pc, in_inst    : fetched beat
//   flush             : discard held and incoming beats
//   id_valid/id_ready : decode-side handshake
//   id_pc, id_pc4     : held PC and registered PC+4
//   id_inst           : held instruction, NOP_INST when not valid
//   stall_cnt         : cycles with id_valid & ~id_ready (not counted on flush)
//   flush_cnt         : cycles with flush asserted
module if_id_skid_reg
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = cpu_pkg::WIDTH,
    parameter logic [WIDTH-1:0] NOP_INST = cpu_pkg::NOP_INST,
    parameter int               CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_inst,
    input  logic             flush,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc4,
    output logic [WIDTH-1:0] id_inst,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] inst;
    } beat_t;

    beat_t            in_beat;
    beat_t            out_d;
    beat_t            out_q;
    beat_t            skd_q;
    logic             out_vld;
    logic             skd_vld;
    logic             out_load;
    logic             out_clr;
    logic             skd_load;
    logic             skd_clr;
    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] pc4_r;

    assign in_beat = '{pc: in_pc, inst: in_inst};
    assign in_ready = ~skd_vld;
    assign accept   = in_valid & in_ready;
    assign drain    = out_vld & id_ready;

    // Slot control: flush first, then refill a free OUT (skid beat has
    // priority to keep order), otherwise park an accepted beat in SKD.
    always_comb begin
        out_load = 1'b0;
        out_clr  = 1'b0;
        skd_load = 1'b0;
        skd_clr  = 1'b0;
        out_d    = in_beat;
        if (flush) begin
            out_clr = 1'b0 | 1'b1;
            skd_clr = 1'b1;
        end else if (!out_vld || drain) begin
            if (skd_vld) begin
                out_load = 1'b1;
                out_d    = skd_q;
                if (accept) skd_load = 1'b1;
                else        skd_clr  = 1'b1;
            end else if (accept) begin
                out_load = 1'b1;
            end else begin
                out_clr = 1'b1;
            end
        end else if (accept) begin
            skd_load = 1'b1;
        end
    end

    // ---- OUT / SKD register stage ----
    pipe_slot #(.beat_t(beat_t)) u_out (
        .clk  (clk),
        .rst  (rst),
        .load (out_load),
        .clr  (out_clr),
        .d    (out_d),
        .vld  (out_vld),
        .q    (out_q)
    );

    pipe_slot #(.beat_t(beat_t)) u_skd (
        .clk  (clk),
        .rst  (rst),
        .load (skd_load),
        .clr  (skd_clr),
        .d    (in_beat),
        .vld  (skd_vld),
        .q    (skd_q)
    );

    // pc+4 is computed as OUT loads so decode sees it straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc4_r <= '0;
        end else if (out_load) begin
            pc4_r <= out_d.pc + WIDTH'(PC_INC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_vld && !id_ready && !flush) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush)                          flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign id_valid = out_vld;
    assign id_pc    = out_q.pc;
    assign id_pc4   = pc4_r;
    assign id_inst  = out_vld ? out_q.inst : NOP_INST;

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } beat_t;

    beat_t q[$];

    if_id_skid_reg #(
        .WIDTH    (32),
        .NOP_INST (32'h0000_0000),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc     (id_pc),
        .id_pc4    (id_pc4),
        .id_inst   (id_inst),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
        id_ready = rdy;
        flush    = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #2;
        check("rst_id_valid", {31'b0, id_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_id_inst", id_inst, 32'h0);
        check("rst_id_pc4", id_pc4, 32'h0);
        check("rst_stall_cnt", {28'b0, stall_cnt}, 32'd0);
        check("rst_flush_cnt", {28'b0, flush_cnt}, 32'd0);
        tick();
        rst = 1'b0;

        // Streaming, no bubbles
        drive(1'b1, 32'h00, 32'h2008_0001, 1'b1, 1'b0);
        tick();
        check("s0_valid", {31'b0, id_valid}, 32'd1);
        check("s0_pc", id_pc, 32'h00);
        check("s0_inst", id_inst, 32'h2008_0001);
        check("s0_pc4", id_pc4, 32'h04);
        drive(1'b1, 32'h04, 32'h2009_0002, 1'b1, 1'b0);
        tick();
        check("s1_pc", id_pc, 32'h04);
        check("s1_inst", id_inst, 32'h2009_0002);
        check("s1_pc4", id_pc4, 32'h08);
        drive(1'b1, 32'h08, 32'h0109_5020, 1'b1, 1'b0);
        tick();
        check("s2_valid", {31'b0, id_valid}, 32'd1);
        check("s2_pc", id_pc, 32'h08);
        check("s2_inst", id_inst, 32'h0109_5020);
        check("s2_pc4", id_pc4, 32'h0C);
        drive(1'b0, 32'h0C, 32'h0, 1'b1, 1'b0);
        tick();
        check("s3_empty", {31'b0, id_valid}, 32'd0);
        check("s3_nop", id_inst, 32'h0);

        // Stall absorb
        drive(1'b1, 32'h100, 32'hA100, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h104, 32'hA104, 1'b0, 1'b0);
        tick();
        check("st_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h108, 32'hA108, 1'b0, 1'b0);
        tick();
        tick();
        check("st_hold_pc", id_pc, 32'h100);
        check("st_hold_inst", id_inst, 32'hA100);
        check("st_in_ready2", {31'b0, in_ready}, 32'd0);
        check("st_stall_cnt", {28'b0, stall_cnt}, 32'd3);
        drive(1'b1, 32'h108, 32'hA108, 1'b1, 1'b0);
        tick();
        check("st_r0_pc", id_pc, 32'h104);
        check("st_r0_pc4", id_pc4, 32'h108);
        check("st_r0_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("st_r1_pc", id_pc, 32'h108);
        check("st_r1_inst", id_inst, 32'hA108);
        drive(1'b0, 32'h10C, 32'h0, 1'b1, 1'b0);
        tick();
        check("st_r2_empty", {31'b0, id_valid}, 32'd0);

        // Flush with skid full
        drive(1'b1, 32'h200, 32'hB200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h204, 32'hB204, 1'b0, 1'b0);
        tick();
        check("fl_full", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 32'h208, 32'hB208, 1'b0, 1'b1);
        tick();
        check("fl_id_valid", {31'b0, id_valid}, 32'd0);
        check("fl_id_inst", id_inst, 32'h0);
        check("fl_in_ready", {31'b0, in_ready}, 32'd1);
        check("fl_flush_cnt", {28'b0, flush_cnt}, 32'd1);
        check("fl_stall_cnt", {28'b0, stall_cnt}, 32'd4);
        drive(1'b1, 32'h400, 32'hC400, 1'b1, 1'b0);
        tick();
        check("fl_next_pc", id_pc, 32'h400);
        check("fl_next_inst", id_inst, 32'hC400);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check("fl_alone", {31'b0, id_valid}, 32'd0);
        // Flush with accept while empty: beat dropped
        drive(1'b1, 32'h500, 32'hC500, 1'b1, 1'b1);
        #1;
        check("fla_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("fla_dropped", {31'b0, id_valid}, 32'd0);
        check("fla_flush_cnt", {28'b0, flush_cnt}, 32'd2);

        // Async reset mid-run with OUT and SKD full
        drive(1'b1, 32'h600, 32'hD600, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h604, 32'hD604, 1'b0, 1'b0);
        tick();
        check("ar_pre_valid", {31'b0, id_valid}, 32'd1);
        check("ar_pre_full", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("ar_id_valid", {31'b0, id_valid}, 32'd0);
        check("ar_in_ready", {31'b0, in_ready}, 32'd1);
        check("ar_id_inst", id_inst, 32'h0);
        check("ar_stall_cnt", {28'b0, stall_cnt}, 32'd0);
        check("ar_flush_cnt", {28'b0, flush_cnt}, 32'd0);
        #1;
        rst = 1'b0;

        // First accept after reset, then counter wrap: 17 stalls -> 1
        drive(1'b1, 32'h700, 32'hE700, 1'b0, 1'b0);
        tick();
        check("cw_first_pc", id_pc, 32'h700);
        check("cw_first_pc4", id_pc4, 32'h704);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) tick();
        check("cw_stall_wrap", {28'b0, stall_cnt}, 32'd1);
        check("cw_hold_pc", id_pc, 32'h700);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // PC wrap
        drive(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 1'b0);
        tick();
        check("pw_pc", id_pc, 32'hFFFF_FFFC);
        check("pw_pc4", id_pc4, 32'h0000_0000);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Randomized with scoreboard
        q.delete();
        for (int cyc = 0; cyc < 5000; cyc++) begin
            logic acc;
            logic drn;
            beat_t nb;
            check("rnd_id_valid", {31'b0, id_valid}, {31'b0, q.size() != 0});
            check("rnd_in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
            if (q.size() != 0) begin
                check("rnd_pc", id_pc, q[0].pc);
                check("rnd_inst", id_inst, q[0].inst);
                check("rnd_pc4", id_pc4, q[0].pc + 32'd4);
            end else begin
                check("rnd_nop", id_inst, 32'h0);
            end
            nb.pc   = $urandom;
            nb.inst = $urandom;
            drive($urandom_range(0, 3) != 0, nb.pc, nb.inst,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            acc = in_valid & (q.size() < 2);
            drn = (q.size() != 0) & id_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) q.push_back(nb);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_skid_reg.md
Name: if_id_skid_reg

Overview:
- Pipeline boundary between the fetch stage and the decode stage.
- Fetch side: the 32-bit PC register plus the instruction memory. Decode side: register file read and control.
- Registers {pc, inst, pc+4} with a valid/ready handshake, a one-entry skid buffer to absorb decode stalls without losing a fetched beat, and a flush that inserts bubbles.
- Also keeps stall and flush event counters for debug.

Parameters:
- WIDTH, 32, data path width of pc and instruction.
- NOP_INST, 32'h00000000, instruction value presented to decode when the output is not valid.
- CNT_W, 32, width of the debug counters.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents a beat.
- in_ready  out  1  block can accept a beat this cycle.
- in_pc  in  WIDTH  PC of the fetched instruction, taken from the PC register output.
- in_inst  in  WIDTH  instruction word from imem.
- flush  in  1  discard all held and incoming beats (branch/jump taken).
- id_valid  out  1  decode-side beat valid.
- id_ready  in  1  decode accepts the beat; the inverse of decode stall.
- id_pc  out  WIDTH  PC of the held instruction.
- id_pc4  out  WIDTH  id_pc + 4, mod 2^WIDTH.
- id_inst  out  WIDTH  held instruction, or NOP_INST when id_valid=0.
- stall_cnt  out  CNT_W  cycles with id_valid=1 and id_ready=0.
- flush_cnt  out  CNT_W  number of cycles with flush=1.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, skid_valid=0.
  - id_pc=0, id_pc4=0, internal inst=0.
  - stall_cnt=0, flush_cnt=0.
  - While in reset: in_ready=1 and id_inst=NOP_INST.
- Storage: output register OUT {pc, inst, valid} and skid register SKD {pc, inst, valid}. id_pc4 is registered and computed on load.
- in_ready = ~skid_valid. It depends on registered state only, with no combinational path from id_ready.
- accept = in_valid & in_ready. drain = out_valid & id_ready.
- Next-state priority, evaluated each rising edge:
  1. flush=1:
     - out_valid<=0, skid_valid<=0.
     - Incoming beat dropped even if accept=1.
     - Data registers may hold stale values.
  2. Otherwise, OUT free (out_valid=0 or drain):
     - If skid_valid: OUT<=SKD, skid_valid<=accept, and SKD<=input if accept.
     - Else if accept: OUT<=input, out_valid<=1.
     - Else: out_valid<=0.
  3. Otherwise, OUT held (out_valid=1, id_ready=0):
     - If accept: SKD<=input, skid_valid<=1.
     - Else: no change.
- Ordering: beats reach decode in acceptance order. No beat is duplicated or lost except by flush.
- Latency: 1 cycle from accept to id_valid with an empty pipe. Throughput is 1 beat/cycle while id_ready=1.
- Full condition: OUT and SKD both valid ⇒ in_ready=0. Fetch must hold its PC (drive PC register CE=0).
- Decode stall for N cycles: at most one extra beat is absorbed, then in_ready drops the next cycle.
- flush together with id_ready=0: the flush wins. id_valid=0 next cycle.
- flush together with accept: the beat is dropped. in_ready is still reported as 1, so fetch advances; the redirect PC comes from the flush source.
- id_inst = out_valid ? OUT.inst : NOP_INST. This is combinational from registered state.
- Counters:
  - stall_cnt increments when id_valid & ~id_ready & ~flush.
  - flush_cnt increments when flush=1.
  - Both wrap at 2^CNT_W.
- Reset asserted mid-operation: all state clears immediately (async). The first accept after deassertion behaves as with an empty pipe.
- PC wrap: in_pc=32'hFFFFFFFC ⇒ id_pc4=32'h00000000.

Decomposition:
- Shared package (cpu_pkg):
  - WIDTH, NOP_INST constant (MIPS sll $0,$0,0 = 0).
  - Typedef for the fetch beat {pc, inst}.
  - PC increment constant 4.
- One natural sub-module, pipe_slot: a single {valid, pc, inst} register with load/clear and async reset, instantiated twice (OUT and SKD).
- Counters and the control decode stay in the top module.

Test Plan:
- Reset check: rst pulse mid-run with OUT and SKD full -> id_valid=0, in_ready=1, id_inst=0, stall_cnt=0 and flush_cnt=0 immediately, without waiting for a clock edge.
- Streaming: in_pc=0x00,0x04,0x08 with inst=0x20080001,0x20090002,0x01095020, in_valid=1, id_ready=1 -> each appears one cycle later with id_pc4=pc+4 and no bubbles.
- Stall absorb: hold id_ready=0 for 3 cycles while streaming from 0x100 -> OUT holds 0x100, SKD takes 0x104, in_ready=0 for the remainder, stall_cnt=3; on release, 0x100 then 0x104 then 0x108, with no loss or duplication.
- Flush with skid full: OUT=0x200, SKD=0x204, flush=1 with in_valid=1 (0x208) -> next cycle id_valid=0, id_inst=0, in_ready=1, flush_cnt=1; next accept 0x400 appears alone.
- Wrap: in_pc=0xFFFFFFFC -> id_pc4=0x00000000. Counter wrap (CNT_W=4 build): 17 stall cycles -> stall_cnt=1.
- Randomized valid/ready/flush with a scoreboard (5000 cycles) -> decode-side sequence equals accepted beats minus those flushed, and in_ready never 1 while skid_valid=1.
